wb_arbiter: RTL

//   Writeback arbiter driving the register bank's two write ports (wrd_en1/2, wrd_add1/2, wrd_data1/2).

---
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-source result handshake plus the two register-bank write ports.
interface wb_arbiter_if #(
  parameter int NSRC = 4,
  parameter int XLEN = 32
);
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC*5-1:0]    src_rd;
  logic [NSRC*XLEN-1:0] src_data;
  logic                 wrd_en1;
  logic [4:0]           wrd_add1;
  logic [XLEN-1:0]      wrd_data1;
  logic                 wrd_en2;
  logic [4:0]           wrd_add2;
  logic [XLEN-1:0]      wrd_data2;
  logic                 wb_idle;

  modport master (
    output src_valid, src_rd, src_data,
    input  src_ready, wrd_en1, wrd_add1, wrd_data1,
    input  wrd_en2, wrd_add2, wrd_data2, wb_idle
  );

  modport slave (
    input  src_valid, src_rd, src_data,
    output src_ready, wrd_en1, wrd_add1, wrd_data1,
    output wrd_en2, wrd_add2, wrd_data2, wb_idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Dual-port writeback arbiter: per-source FIFOs, round-robin selection, no same-rd dual write.
// Optional WB_BYPASS_EN lets an empty source's live result compete directly as its head.
module wb_arbiter #(
  parameter int NSRC  = 4,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input logic         clk,
  input logic         reset,
  input logic         flush,
  wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(NSRC);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + XLEN;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [EW-1:0]   mem    [NSRC][DEPTH];
  logic [AW-1:0]   wr_ptr [NSRC];
  logic [AW-1:0]   rd_ptr [NSRC];
  logic [AW:0]     count  [NSRC];
  logic [NSRC-1:0] empty, full, push, pop, gnt;

  logic [NSRC-1:0] cand_vld, cand_byp;
  logic [4:0]      cand_rd   [NSRC];
  logic [XLEN-1:0] cand_data [NSRC];

  logic [SW-1:0]   rr_ptr;
  logic            p1_vld, p2_vld;
  logic [SW-1:0]   p1_src, p2_src;
  logic [4:0]      p1_rd;

  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      empty[i]     = (count[i] == '0);
      full[i]      = (count[i] == CNT_FULL);
      cand_vld[i]  = !empty[i];
      cand_byp[i]  = 1'b0;
      cand_rd[i]   = mem[i][rd_ptr[i]][EW-1:XLEN];
      cand_data[i] = mem[i][rd_ptr[i]][XLEN-1:0];
`ifdef WB_BYPASS_EN
      if (empty[i] && bus.src_valid[i] && bus.src_rd[5*i +: 5] != 5'd0) begin
        cand_vld[i]  = 1'b1;
        cand_byp[i]  = 1'b1;
        cand_rd[i]   = bus.src_rd[5*i +: 5];
        cand_data[i] = bus.src_data[XLEN*i +: XLEN];
      end
`endif
    end
  end

  always_comb bus.src_ready = ~full & {NSRC{~reset}};

  // Scan from rr_ptr; a head colliding with port 1's rd is skipped but keeps its place.
  always_comb begin
    int unsigned idx;
    logic [SW-1:0] s;
    idx    = 0;
    s      = '0;
    p1_vld = 1'b0;
    p2_vld = 1'b0;
    p1_src = '0;
    p2_src = '0;
    p1_rd  = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      s = SW'(idx);
      if (cand_vld[s] && !flush) begin
        if (!p1_vld) begin
          p1_vld = 1'b1;
          p1_src = s;
          p1_rd  = cand_rd[s];
        end else if (!p2_vld && cand_rd[s] != p1_rd) begin
          p2_vld = 1'b1;
          p2_src = s;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      gnt[i]  = (p1_vld && p1_src == SW'(i)) || (p2_vld && p2_src == SW'(i));
      pop[i]  = gnt[i] & ~cand_byp[i];
      // rd == 0 completes the handshake but is never stored.
      push[i] = bus.src_valid[i] & bus.src_ready[i] & (bus.src_rd[5*i +: 5] != 5'd0)
                & ~flush & ~(gnt[i] & cand_byp[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {bus.src_rd[5*i +: 5], bus.src_data[XLEN*i +: XLEN]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr        <= '0;
      bus.wrd_en1   <= 1'b0;
      bus.wrd_add1  <= '0;
      bus.wrd_data1 <= '0;
      bus.wrd_en2   <= 1'b0;
      bus.wrd_add2  <= '0;
      bus.wrd_data2 <= '0;
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (flush) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
          case ({push[i], pop[i]})
            2'b10:   count[i] <= count[i] + (AW+1)'(1);
            2'b01:   count[i] <= count[i] - (AW+1)'(1);
            default: count[i] <= count[i];
          endcase
        end
      end
      if (p1_vld) rr_ptr <= (p1_src == SW'(NSRC-1)) ? '0 : p1_src + SW'(1);
      bus.wrd_en1 <= p1_vld;
      bus.wrd_en2 <= p2_vld;
      if (p1_vld) begin
        bus.wrd_add1  <= cand_rd[p1_src];
        bus.wrd_data1 <= cand_data[p1_src];
      end
      if (p2_vld) begin
        bus.wrd_add2  <= cand_rd[p2_src];
        bus.wrd_data2 <= cand_data[p2_src];
      end
    end
  end

  always_comb bus.wb_idle = (&empty) & ~bus.wrd_en1 & ~bus.wrd_en2;

endmodule
